vga_sprite_compositor: RTL

- Parametrised successor of the single-box pixel generator.
- Composites NUM_SPRITES fixed-size rectangular sprites over a background colour, using the VGA timing counters.
- Sprite positions and enables are written through a valid/ready config port into pending registers, then committed to shadow registers at frame start so there is no tearing.
- Output is registered, with fixed 2-cycle latency, and includes per-frame collision detection for sprite 0 (the player ship).

---
 rtl/vga_sprite_compositor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_compositor.sv
// Composites NUM_SPRITES rectangular sprites over a background with a 2-stage
// registered pipeline, tear-free config commit and sprite-0 collision flags.
// Optional colour-key transparency is enabled with `define TRANSPARENCY_KEY_EN.
module vga_sprite_compositor #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 11,
   parameter int COLOR_W     = 8,
   parameter int SPRITE_W    = 40,
   parameter int SPRITE_H    = 40,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480
`ifdef TRANSPARENCY_KEY_EN
   ,
   parameter logic [3*COLOR_W-1:0] KEY_RGB =
      {{COLOR_W{1'b1}}, {COLOR_W{1'b0}}, {COLOR_W{1'b1}}}
`endif
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [COORD_W-1:0]                 counth,
   input  logic [COORD_W-1:0]                 countv,
   input  logic [NUM_SPRITES*3*COLOR_W-1:0]   spr_rgb,
   input  logic [COLOR_W-1:0]                 backgroundr,
   input  logic [COLOR_W-1:0]                 backgroundg,
   input  logic [COLOR_W-1:0]                 backgroundb,
   input  logic                               cfg_valid,
   output logic                               cfg_ready,
   input  logic [$clog2(NUM_SPRITES)-1:0]     cfg_idx,
   input  logic [COORD_W-1:0]                 cfg_x,
   input  logic [COORD_W-1:0]                 cfg_y,
   input  logic                               cfg_en,
   output logic [COLOR_W-1:0]                 vga_r,
   output logic [COLOR_W-1:0]                 vga_g,
   output logic [COLOR_W-1:0]                 vga_b,
   output logic [NUM_SPRITES-1:0]             hit_mask,
   output logic                               collision,
   output logic                               collision_last
);

   localparam int IDX_W = $clog2(NUM_SPRITES);
   localparam int RGB_W = 3 * COLOR_W;
   localparam int XW    = COORD_W + 1;

   logic [COORD_W-1:0]           pend_x [NUM_SPRITES];
   logic [COORD_W-1:0]           pend_y [NUM_SPRITES];
   logic [NUM_SPRITES-1:0]       pend_en;
   logic [COORD_W-1:0]           shd_x  [NUM_SPRITES];
   logic [COORD_W-1:0]           shd_y  [NUM_SPRITES];
   logic [NUM_SPRITES-1:0]       shd_en;

   logic                         frame_start;
   logic                         cfg_wr;
   logic [NUM_SPRITES-1:0]       hit_c;
   logic [XW-1:0]                h_ext, v_ext, eff_x, eff_y;
   logic                         eff_en;

   logic [NUM_SPRITES-1:0]       s1_hit;
   logic                         s1_active;
   logic [NUM_SPRITES*RGB_W-1:0] s1_rgb;
   logic [RGB_W-1:0]             s1_bg;
   logic [NUM_SPRITES-1:0]       opaque;
   logic [RGB_W-1:0]             pix_c;
   logic                         coll_set;

   assign frame_start = (counth == '0) && (countv == '0);
   assign cfg_ready   = !frame_start;
   assign cfg_wr      = cfg_valid && cfg_ready;
   assign h_ext       = {1'b0, counth};
   assign v_ext       = {1'b0, countv};

   // Out-of-range indices match no sprite, so such writes are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            pend_x[i] <= '0;
            pend_y[i] <= '0;
            shd_x[i]  <= '0;
            shd_y[i]  <= '0;
         end
         pend_en <= '0;
         shd_en  <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (cfg_wr && (cfg_idx == IDX_W'(i))) begin
               pend_x[i]  <= cfg_x;
               pend_y[i]  <= cfg_y;
               pend_en[i] <= cfg_en;
            end
            if (frame_start) begin
               shd_x[i]  <= pend_x[i];
               shd_y[i]  <= pend_y[i];
               shd_en[i] <= pend_en[i];
            end
         end
      end
   end

   // Pending values are bypassed in the commit cycle so pixel (0,0) already
   // sees the new frame's positions.
   always_comb begin
      hit_c  = '0;
      eff_x  = '0;
      eff_y  = '0;
      eff_en = 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         eff_x  = frame_start ? {1'b0, pend_x[i]} : {1'b0, shd_x[i]};
         eff_y  = frame_start ? {1'b0, pend_y[i]} : {1'b0, shd_y[i]};
         eff_en = frame_start ? pend_en[i] : shd_en[i];
         hit_c[i] = eff_en
                  && (h_ext >= eff_x) && (h_ext < eff_x + XW'(SPRITE_W))
                  && (v_ext >= eff_y) && (v_ext < eff_y + XW'(SPRITE_H));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit    <= '0;
         s1_active <= 1'b0;
         s1_rgb    <= '0;
         s1_bg     <= '0;
      end else begin
         s1_hit    <= hit_c;
         s1_active <= (counth < COORD_W'(H_ACTIVE)) && (countv < COORD_W'(V_ACTIVE));
         s1_rgb    <= spr_rgb;
         s1_bg     <= {backgroundr, backgroundg, backgroundb};
      end
   end

`ifdef TRANSPARENCY_KEY_EN
   always_comb begin
      opaque = '0;
      for (int i = 0; i < NUM_SPRITES; i++)
         opaque[i] = s1_hit[i] && (s1_rgb[i*RGB_W +: RGB_W] != KEY_RGB);
   end
`else
   assign opaque = s1_hit;
`endif

   // Walk from lowest priority upward so sprite 0 is applied last.
   always_comb begin
      pix_c = s1_bg;
      for (int i = NUM_SPRITES - 1; i >= 0; i--)
         if (opaque[i]) pix_c = s1_rgb[i*RGB_W +: RGB_W];
   end

   assign coll_set = s1_active && opaque[0] && (|(opaque >> 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r          <= '0;
         vga_g          <= '0;
         vga_b          <= '0;
         hit_mask       <= '0;
         collision      <= 1'b0;
         collision_last <= 1'b0;
      end else begin
         if (s1_active) begin
            {vga_r, vga_g, vga_b} <= pix_c;
            hit_mask              <= s1_hit;
         end else begin
            {vga_r, vga_g, vga_b} <= '0;
            hit_mask              <= '0;
         end
         if (frame_start) begin
            collision_last <= collision || coll_set;
            collision      <= 1'b0;
         end else if (coll_set) begin
            collision <= 1'b1;
         end
      end
   end

endmodule
